// File: rtl/pc_ctrl.sv
// Program-counter controller: sequences start/halt/done and
// redirects the PC through the branch LUT on taken branches.
module pc_ctrl #(
  parameter int PC_W     = 12,
  parameter int KEY_W    = 5,
  parameter int START_PC = 0,
  parameter int PROG_END = 4095,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_i,
  input  logic             branch_en,
  input  logic             branch_cond,
  input  logic [KEY_W-1:0] branch_key,
  input  logic [PC_W-1:0]  branch_pos,
  output logic             branch_lut_en,
  output logic [KEY_W-1:0] key,
  output logic [PC_W-1:0]  pc,
  output logic             flush,
  output logic             done,
  output logic             bad_target,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [PC_W-1:0] START_V = PC_W'(START_PC);
  localparam logic [PC_W-1:0] END_V   = PC_W'(PROG_END);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             done_q, done_d;
  logic             bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             running;
  logic             taken;
  logic             target_zero;
  logic             at_end;
  logic [CNT_W-1:0] cnt_inc;
  logic [PC_W-1:0]  pc_inc;

  assign running     = (state_q == S_RUN);
  assign taken       = running & branch_en
                     & branch_cond & ~stall;
  assign target_zero = (branch_pos == '0);
  assign at_end      = (pc_q == END_V);
  assign pc_inc      = pc_q + PC_ONE;
  // Saturate rather than wrap so long programs stay monotonic.
  assign cnt_inc     = (&cnt_q) ? cnt_q
                                : cnt_q + CNT_ONE;

  assign branch_lut_en = taken;
  assign key           = branch_key;
  assign pc            = pc_q;
  assign flush         = flush_q;
  assign done          = done_q;
  assign bad_target    = bad_q;
  assign instr_count   = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    done_d  = done_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_V;
          done_d  = 1'b0;
          bad_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          cnt_d = cnt_inc;
          if (halt_i) begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end else if (taken && target_zero) begin
            // Unmapped LUT key: stop rather than jump to 0.
            state_d = S_HALT;
            done_d  = 1'b1;
            bad_d   = 1'b1;
          end else if (taken) begin
            pc_d    = branch_pos;
            flush_d = 1'b1;
          end else if (at_end) begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_V;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
